// File: rtl/vend_credit_if.sv
// Coin-acceptor / actuator bundle for the vending credit controller.
// The master drives coin and cancel requests; the slave returns credit and actuator pulses.
interface vend_credit_if #(
  parameter int COIN_W   = 3,
  parameter int CREDIT_W = 5
);
  logic                i_coin_vld;
  logic [COIN_W-1:0]   i_coin;
  logic                i_cancel;
  logic [CREDIT_W-1:0] o_credit;
  logic                o_coin_reject;
  logic                o_dispense;
  logic                o_change_vld;
  logic [CREDIT_W-1:0] o_change_amt;
  logic                o_busy;

  modport master (
    output i_coin_vld, i_coin, i_cancel,
    input  o_credit, o_coin_reject, o_dispense, o_change_vld, o_change_amt, o_busy
  );

  modport slave (
    input  i_coin_vld, i_coin, i_cancel,
    output o_credit, o_coin_reject, o_dispense, o_change_vld, o_change_amt, o_busy
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// Coin-credit controller: accumulates coins, dispenses one item at PRICE, then pays back
// the remainder (or the whole credit on cancel) in steps of at most CHANGE_UNIT.
module vend_credit_fsm #(
  parameter int COIN_W      = 3,
  parameter int CREDIT_W    = 5,
  parameter int PRICE       = 6,
  parameter int MAX_CREDIT  = 31,
  parameter int CHANGE_UNIT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  vend_credit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0]   PRICE_X = PRICE[CREDIT_W:0];
  localparam logic [CREDIT_W:0]   MAX_X   = MAX_CREDIT[CREDIT_W:0];
  localparam logic [CREDIT_W-1:0] PRICE_C = PRICE[CREDIT_W-1:0];

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [CREDIT_W:0]   sum;
  logic                coin_nz;
  logic                accept;
  logic [CREDIT_W-1:0] step_amt;

  function automatic logic [CREDIT_W-1:0] change_step(input logic [CREDIT_W-1:0] c);
    if (int'(c) >= CHANGE_UNIT) return CHANGE_UNIT[CREDIT_W-1:0];
    return c;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  // Extra top bit on the sum keeps an oversized coin from wrapping past MAX_CREDIT.
  always_comb begin
    sum      = {1'b0, credit_q} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, bus.i_coin};
    coin_nz  = bus.i_coin_vld && (bus.i_coin != '0);
    accept   = coin_nz && (state_q == S_IDLE || state_q == S_COLLECT)
               && !bus.i_cancel && (sum <= MAX_X);
    reject_d = coin_nz && !accept;
    step_amt = change_step(credit_q);
    state_d  = state_q;
    credit_d = credit_q;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept) begin
          credit_d = sum[CREDIT_W-1:0];
          state_d  = (sum >= PRICE_X) ? S_DISPENSE : S_COLLECT;
        end else if (state_q == S_COLLECT && bus.i_cancel) begin
          state_d = S_CHANGE;
        end
      end
      S_DISPENSE: begin
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
      end
      S_CHANGE: begin
        credit_d = credit_q - step_amt;
        if (credit_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_credit      = credit_q;
  assign bus.o_coin_reject = reject_q;
  assign bus.o_dispense    = (state_q == S_DISPENSE);
  assign bus.o_change_vld  = (state_q == S_CHANGE);
  assign bus.o_change_amt  = (state_q == S_CHANGE) ? step_amt : '0;
  assign bus.o_busy        = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule
